lis3dh_spi_sequencer: RTL and testbench
=======================================

// Module: lis3dh_spi_sequencer
// PURPOSE
//  Autonomous Avalon-MM master driving the 8-bit SPI master core's register port (regs 0..6) to run the LIS3DH.
//  After reset it clears status and writes CTRL_REG1; then it burst-reads OUT_X_L..OUT_Z_H every SAMPLE_PERIOD clocks.
//  It delivers signed X/Y/Z words with a valid pulse to the fabric, replacing CPU polling of the SPI core.
// PARAMETERS
//  SAMPLE_PERIOD  500000  clocks between burst starts (>= one burst length); 100 Hz at 50 MHz
//  CTRL_REG1_VAL  8'h57   byte written to LIS3DH reg 0x20 (100 Hz ODR, XYZ enabled)
//  RX_TIMEOUT     2048    clocks to wait for dataavailable per byte before error
// PORTS
//  clk            in   1   system clock (50 MHz)
//  reset_n        in   1   reset; synchronous, active-low
//  spi_select     out  1   chip select to the SPI core register port
//  spi_mem_addr   out  3   register address (0 rxdata, 1 txdata, 2 status, 3 control)
//  spi_read_n     out  1   read strobe, active-low
//  spi_write_n    out  1   write strobe, active-low
//  spi_wrdata     out  16  write data (data_from_cpu of the SPI core)
//  spi_rddata     in   16  read data (data_to_cpu of the SPI core)
//  spi_dataavail  in   1   SPI core RRDY (dataavailable)
//  enable         in   1   1 = periodic sampling runs; 0 = finish current burst, then stay idle
//  sample_x/y/z   out  16  {OUT_*_H, OUT_*_L}, two's complement, left-justified
//  sample_valid   out  1   one-cycle pulse; sample_x/y/z updated in the same cycle
//  busy           out  1   1 while any SPI frame is in progress
//  timeout_err    out  1   sticky; set on RX_TIMEOUT expiry, cleared only by reset
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): all outputs 0; spi_read_n=spi_write_n=1; FSM=CLR; period counter=0.
//  Bus access (3 cycles, sub-module): A0,A1 drive select=1, the strobe=0, addr, wrdata (held stable).
//   A2 is idle: select=0, strobes=1.
//   Read data is captured at the end of A1. Accesses never overlap. Back-to-back accesses are separated by A2.
//  Frame = write ctrl(3)=16'h0400 (SSO=1), then per byte:
//   write txdata(1)=byte; wait spi_dataavail=1; read rxdata(0), capture [7:0].
//   Then write ctrl(3)=16'h0000 (SSO=0, SS_n released).
//  FSM: CLR (write status(2)=0, clears ROE/TOE/RRDY/EOP) -> INIT (frame 8'h20,CTRL_REG1_VAL) -> IDLE.
//   IDLE -> BURST when period counter hits SAMPLE_PERIOD-1 and enable=1.
//   BURST = frame 8'hE8 (read|auto-incr|0x28), then six 8'h00 dummies -> DONE -> IDLE.
//  DONE: sample_x={rx2,rx1}, sample_y={rx4,rx3}, sample_z={rx6,rx5}; sample_valid=1 for exactly one cycle.
//  Period counter free-runs 0..SAMPLE_PERIOD-1 and wraps; a tick during a burst is dropped (no queueing).
//  enable deassert mid-burst: the burst completes and emits its sample; no new burst starts.
//  Timeout: a wait exceeding RX_TIMEOUT clocks sets timeout_err, still writes ctrl=0 (SS released), returns to IDLE.
//   A timed-out burst emits no sample_valid; later bursts still run.
//  spi_dataavail already 1 on entry to a wait: proceed the next cycle (no edge detect).
//  Reset mid-access: strobes deassert the same edge; the SPI core finishes its byte on its own.
//   The sequence restarts at CLR, whose status write clears ROE.
//  busy=1 from the first access of CLR/INIT/BURST until the last A2 of its ctrl=0 write.
// CONFIGURATION
//  LIS3DH_WHOAMI_CHECK_EN defined: after CLR, run frame 8'h8F,8'h00 (read WHO_AM_I) before INIT.
//   Adds output id_err (1 bit, sticky, reset 0), set if the byte != 8'h33.
//   Sequencing continues regardless.
//  Undefined: no WHO_AM_I frame and no id_err port; CLR goes straight to INIT.
// STRUCTURE
//  Package lis3dh_seq_pkg:
//   - SPI core register address constants (RX=0, TX=1, STATUS=2, CONTROL=3).
//   - CTRL_SSO=16'h0400.
//   - LIS3DH constants (REG_CTRL1=8'h20, CMD_BURST_XYZ=8'hE8, CMD_WHOAMI=8'h8F, WHOAMI_VAL=8'h33).
//   - FSM state enum.
//  Sub-module spi_reg_access: the 3-cycle access engine.
//   - Inputs: req, we, addr, wdata.
//   - Outputs: ack (pulse at A2), rdata.
//  The top level holds the FSM, byte index (0..6), timeout and period counters, and sample registers.
// TESTING
//  Bench pairs the DUT with the real SPI core, plus a LIS3DH SPI slave model (mode 0) with a register file.
//  1 Reset release:
//   - first access is write addr2 data 0, then write addr3 16'h0400.
//   - MOSI carries 8'h20 then 8'h57.
//   - SS_n high after the ctrl=0 write.
//  2 Model OUT regs 28..2D = 01,80,FF,7F,00,00 -> sample_x=16'h8001, y=16'h7FFF, z=16'h0000.
//   - sample_valid high for 1 cycle; SS_n low across all 7 bytes.
//  3 SAMPLE_PERIOD=4000 -> sample_valid pulses spaced exactly 4000 clocks.
//   - enable=0 mid-burst -> that sample emitted, then no further pulses.
//  4 Model stops producing SCLK response (force dataavailable=0 on byte 3) -> after 2048 clocks:
//   - timeout_err=1, ctrl=0 written, no sample_valid; next burst succeeds.
//  5 Assert reset_n=0 for 1 cycle during byte 4 -> strobes high at that edge; sequence restarts at CLR.
//   - CLR clears ROE; the next sample is correct.
//  6 LIS3DH_WHOAMI_CHECK_EN with model WHO_AM_I=8'h32 -> id_err=1, INIT still sent; with 8'h33 -> id_err=0.

Source files
------------

// File: rtl/lis3dh_seq_pkg.sv
// Shared constants and state types for the LIS3DH SPI sequencer.
package lis3dh_seq_pkg;

   // SPI core register port addresses
   localparam logic [2:0]  ADDR_RX      = 3'd0;
   localparam logic [2:0]  ADDR_TX      = 3'd1;
   localparam logic [2:0]  ADDR_STATUS  = 3'd2;
   localparam logic [2:0]  ADDR_CONTROL = 3'd3;

   localparam logic [15:0] CTRL_SSO     = 16'h0400;

   // LIS3DH command and register constants
   localparam logic [7:0]  REG_CTRL1     = 8'h20;
   localparam logic [7:0]  CMD_BURST_XYZ = 8'hE8;
   localparam logic [7:0]  CMD_WHOAMI    = 8'h8F;
   localparam logic [7:0]  WHOAMI_VAL    = 8'h33;

   typedef enum logic [2:0] {
      StClr,
      StWhoami,
      StInit,
      StIdle,
      StBurst,
      StDone
   } seq_state_e;

   typedef enum logic [2:0] {
      StepStart,
      StepSso,
      StepTx,
      StepWait,
      StepRx,
      StepRel
   } step_e;

   typedef enum logic [1:0] {
      PhIdle,
      PhA0,
      PhA1,
      PhA2
   } phase_e;

endpackage

// File: rtl/spi_reg_access.sv
// Three-cycle Avalon-MM access engine for the SPI core register port.
// A0/A1 drive the strobe, A2 is idle and carries the ack pulse.
module spi_reg_access
   import lis3dh_seq_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [2:0]  addr_i,
   input  logic [15:0] wdata_i,
   output logic        ack_o,
   output logic [15:0] rdata_o,
   output logic        spi_select_o,
   output logic [2:0]  spi_mem_addr_o,
   output logic        spi_read_n_o,
   output logic        spi_write_n_o,
   output logic [15:0] spi_wrdata_o,
   input  logic [15:0] spi_rddata_i
);

   phase_e phase_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         phase_q        <= PhIdle;
         ack_o          <= 1'b0;
         rdata_o        <= 16'h0000;
         spi_select_o   <= 1'b0;
         spi_mem_addr_o <= 3'd0;
         spi_read_n_o   <= 1'b1;
         spi_write_n_o  <= 1'b1;
         spi_wrdata_o   <= 16'h0000;
      end else begin
         ack_o <= 1'b0;
         case (phase_q)
            PhIdle: begin
               if (req_i) begin
                  phase_q        <= PhA0;
                  spi_select_o   <= 1'b1;
                  spi_read_n_o   <= we_i;
                  spi_write_n_o  <= ~we_i;
                  spi_mem_addr_o <= addr_i;
                  spi_wrdata_o   <= wdata_i;
               end
            end
            PhA0: phase_q <= PhA1;
            PhA1: begin
               phase_q       <= PhA2;
               ack_o         <= 1'b1;
               spi_select_o  <= 1'b0;
               spi_read_n_o  <= 1'b1;
               spi_write_n_o <= 1'b1;
               if (!spi_read_n_o) rdata_o <= spi_rddata_i;
            end
            default: phase_q <= PhIdle;
         endcase
      end
   end

endmodule

// File: rtl/lis3dh_spi_sequencer.sv
// Autonomous LIS3DH sampler driving the SPI core register port.
// Build option LIS3DH_WHOAMI_CHECK_EN adds a WHO_AM_I frame and the id_err output.
module lis3dh_spi_sequencer
   import lis3dh_seq_pkg::*;
#(
   parameter int unsigned SAMPLE_PERIOD = 500000,
   parameter logic [7:0]  CTRL_REG1_VAL = 8'h57,
   parameter int unsigned RX_TIMEOUT    = 2048
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        spi_select,
   output logic [2:0]  spi_mem_addr,
   output logic        spi_read_n,
   output logic        spi_write_n,
   output logic [15:0] spi_wrdata,
   input  logic [15:0] spi_rddata,
   input  logic        spi_dataavail,
   input  logic        enable,
   output logic [15:0] sample_x,
   output logic [15:0] sample_y,
   output logic [15:0] sample_z,
   output logic        sample_valid,
   output logic        busy,
`ifdef LIS3DH_WHOAMI_CHECK_EN
   output logic        id_err,
`endif
   output logic        timeout_err
);

   localparam int unsigned PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam int unsigned TW = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;
   localparam logic [PW-1:0] PerLast = PW'(SAMPLE_PERIOD - 1);
   localparam logic [TW-1:0] TmoLast = TW'(RX_TIMEOUT - 1);

   seq_state_e    state_q;
   step_e         step_q;
   logic [2:0]    idx_q;
   logic          req_q;
   logic          we_q;
   logic [2:0]    addr_q;
   logic [15:0]   wdata_q;
   logic [PW-1:0] per_q;
   logic [TW-1:0] tmo_q;
   logic          abort_q;
   logic [47:0]   rx_q;
   logic          ack;
   logic [15:0]   rdata;
   logic          unused_rdata;

   assign unused_rdata = ^rdata[15:8];

   function automatic logic [7:0] frame_byte(input seq_state_e st, input logic [2:0] idx);
      if (idx != 3'd0) begin
         frame_byte = (st == StInit) ? CTRL_REG1_VAL : 8'h00;
      end else begin
         case (st)
            StInit:   frame_byte = REG_CTRL1;
            StWhoami: frame_byte = CMD_WHOAMI;
            default:  frame_byte = CMD_BURST_XYZ;
         endcase
      end
   endfunction

   function automatic logic [2:0] last_idx(input seq_state_e st);
      last_idx = (st == StBurst) ? 3'd6 : 3'd1;
   endfunction

   spi_reg_access u_access (
      .clk            (clk),
      .reset_n        (reset_n),
      .req_i          (req_q),
      .we_i           (we_q),
      .addr_i         (addr_q),
      .wdata_i        (wdata_q),
      .ack_o          (ack),
      .rdata_o        (rdata),
      .spi_select_o   (spi_select),
      .spi_mem_addr_o (spi_mem_addr),
      .spi_read_n_o   (spi_read_n),
      .spi_write_n_o  (spi_write_n),
      .spi_wrdata_o   (spi_wrdata),
      .spi_rddata_i   (spi_rddata)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= StClr;
         step_q       <= StepStart;
         idx_q        <= 3'd0;
         req_q        <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= 3'd0;
         wdata_q      <= 16'h0000;
         per_q        <= '0;
         tmo_q        <= '0;
         abort_q      <= 1'b0;
         rx_q         <= 48'h0;
         sample_x     <= 16'h0000;
         sample_y     <= 16'h0000;
         sample_z     <= 16'h0000;
         sample_valid <= 1'b0;
         busy         <= 1'b0;
         timeout_err  <= 1'b0;
`ifdef LIS3DH_WHOAMI_CHECK_EN
         id_err       <= 1'b0;
`endif
      end else begin
         req_q        <= 1'b0;
         sample_valid <= 1'b0;
         per_q        <= (per_q == PerLast) ? '0 : per_q + 1'b1;
         case (state_q)
            // A tick arriving outside IDLE is simply lost
            StIdle: if (per_q == PerLast && enable) state_q <= StBurst;
            StDone: state_q <= StIdle;
            default: begin
               case (step_q)
                  StepStart: begin
                     busy    <= 1'b1;
                     idx_q   <= 3'd0;
                     abort_q <= 1'b0;
                     req_q   <= 1'b1;
                     we_q    <= 1'b1;
                     if (state_q == StClr) begin
                        addr_q  <= ADDR_STATUS;
                        wdata_q <= 16'h0000;
                        step_q  <= StepRel;
                     end else begin
                        addr_q  <= ADDR_CONTROL;
                        wdata_q <= CTRL_SSO;
                        step_q  <= StepSso;
                     end
                  end
                  StepSso: if (ack) begin
                     req_q   <= 1'b1;
                     we_q    <= 1'b1;
                     addr_q  <= ADDR_TX;
                     wdata_q <= {8'h00, frame_byte(state_q, idx_q)};
                     step_q  <= StepTx;
                  end
                  StepTx: if (ack) begin
                     tmo_q  <= '0;
                     step_q <= StepWait;
                  end
                  StepWait: begin
                     if (spi_dataavail) begin
                        req_q  <= 1'b1;
                        we_q   <= 1'b0;
                        addr_q <= ADDR_RX;
                        step_q <= StepRx;
                     end else if (tmo_q == TmoLast) begin
                        // Abandon the frame but still release SS_n
                        timeout_err <= 1'b1;
                        abort_q     <= 1'b1;
                        req_q       <= 1'b1;
                        we_q        <= 1'b1;
                        addr_q      <= ADDR_CONTROL;
                        wdata_q     <= 16'h0000;
                        step_q      <= StepRel;
                     end else begin
                        tmo_q <= tmo_q + 1'b1;
                     end
                  end
                  StepRx: if (ack) begin
                     if (idx_q != 3'd0) rx_q <= {rdata[7:0], rx_q[47:8]};
`ifdef LIS3DH_WHOAMI_CHECK_EN
                     if (state_q == StWhoami && idx_q == 3'd1 && rdata[7:0] != WHOAMI_VAL) begin
                        id_err <= 1'b1;
                     end
`endif
                     req_q <= 1'b1;
                     we_q  <= 1'b1;
                     if (idx_q == last_idx(state_q)) begin
                        addr_q  <= ADDR_CONTROL;
                        wdata_q <= 16'h0000;
                        step_q  <= StepRel;
                     end else begin
                        idx_q   <= idx_q + 3'd1;
                        addr_q  <= ADDR_TX;
                        wdata_q <= {8'h00, frame_byte(state_q, idx_q + 3'd1)};
                        step_q  <= StepTx;
                     end
                  end
                  StepRel: if (ack) begin
                     step_q <= StepStart;
                     if (abort_q) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                     end else begin
                        case (state_q)
                           StClr: begin
`ifdef LIS3DH_WHOAMI_CHECK_EN
                              state_q <= StWhoami;
`else
                              state_q <= StInit;
`endif
                           end
                           StWhoami: state_q <= StInit;
                           StBurst: begin
                              sample_x     <= rx_q[15:0];
                              sample_y     <= rx_q[31:16];
                              sample_z     <= rx_q[47:32];
                              sample_valid <= 1'b1;
                              state_q      <= StDone;
                              busy         <= 1'b0;
                           end
                           default: begin
                              state_q <= StIdle;
                              busy    <= 1'b0;
                           end
                        endcase
                     end
                  end
                  default: step_q <= StepStart;
               endcase
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lis3dh_spi_sequencer.sv
// Scoreboard bench: behavioural SPI core + LIS3DH register-file model around the sequencer.
module tb_lis3dh_spi_sequencer;

   localparam int unsigned Period  = 4000;
   localparam int unsigned Timeout = 2048;
   localparam int          Lat     = 24;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b0;
   logic        spi_select, spi_read_n, spi_write_n;
   logic [2:0]  spi_mem_addr;
   logic [15:0] spi_wrdata, spi_rddata;
   logic        spi_dataavail;
   logic [15:0] sample_x, sample_y, sample_z;
   logic        sample_valid, busy, timeout_err;
`ifdef LIS3DH_WHOAMI_CHECK_EN
   logic        id_err;
`endif

   always #10 clk = ~clk;

   lis3dh_spi_sequencer #(
      .SAMPLE_PERIOD (Period),
      .CTRL_REG1_VAL (8'h57),
      .RX_TIMEOUT    (Timeout)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .spi_select    (spi_select),
      .spi_mem_addr  (spi_mem_addr),
      .spi_read_n    (spi_read_n),
      .spi_write_n   (spi_write_n),
      .spi_wrdata    (spi_wrdata),
      .spi_rddata    (spi_rddata),
      .spi_dataavail (spi_dataavail),
      .enable        (enable),
      .sample_x      (sample_x),
      .sample_y      (sample_y),
      .sample_z      (sample_z),
      .sample_valid  (sample_valid),
      .busy          (busy),
`ifdef LIS3DH_WHOAMI_CHECK_EN
      .id_err        (id_err),
`endif
      .timeout_err   (timeout_err)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   // ---------------- SPI core + LIS3DH model ----------------
   int          cyc = 0;
   logic [7:0]  regs [0:63];
   logic [7:0]  rx_reg = 8'h00;
   logic [7:0]  resp_q = 8'h00;
   logic        rrdy = 1'b0;
   logic        roe = 1'b0;
   logic        ss = 1'b0;
   logic        prev_sel = 1'b0;
   int          cnt = 0;
   int          fbytes = 0;
   logic [7:0]  fcmd = 8'h00;
   int          bursts = 0;
   int          kill_at = -1;
   int          kill_t = 0;
   int          ss_err = 0;
   logic [5:0]  ra;
   logic [18:0] wlog [$];
   logic [7:0]  mosi [$];
   logic [47:0] exp_q [$];

   assign spi_dataavail = rrdy;
   assign spi_rddata    = {8'h00, rx_reg};

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      prev_sel <= spi_select;
      // An abandoned byte would overrun the receive register
      if (!reset_n) roe <= 1'b1;
      if (cnt > 0) begin
         cnt <= cnt - 1;
         if (cnt == 1) begin
            if (rrdy) roe <= 1'b1;
            rrdy   <= 1'b1;
            rx_reg <= resp_q;
         end
      end
      if (spi_select && !prev_sel) begin
         if (!spi_write_n) begin
            wlog.push_back({spi_mem_addr, spi_wrdata});
            case (spi_mem_addr)
               3'd2: begin
                  rrdy <= 1'b0;
                  roe  <= 1'b0;
               end
               3'd3: begin
                  if (!spi_wrdata[10] && fcmd == 8'hE8 && fbytes == 7)
                     exp_q.push_back({regs[6'h29], regs[6'h28], regs[6'h2B], regs[6'h2A],
                                      regs[6'h2D], regs[6'h2C]});
                  ss     <= spi_wrdata[10];
                  fbytes <= 0;
               end
               3'd1: begin
                  mosi.push_back(spi_wrdata[7:0]);
                  if (!ss) ss_err <= ss_err + 1;
                  if (fbytes == 0) begin
                     fcmd   <= spi_wrdata[7:0];
                     resp_q <= 8'h00;
                     if (spi_wrdata[7:0] == 8'hE8) bursts <= bursts + 1;
                  end else begin
                     ra = fcmd[5:0] + (fcmd[6] ? 6'(fbytes - 1) : 6'd0);
                     resp_q <= fcmd[7] ? regs[ra] : 8'h00;
                  end
                  fbytes <= fbytes + 1;
                  if (fcmd == 8'hE8 && fbytes == 3 && bursts == kill_at) kill_t <= cyc;
                  else cnt <= Lat;
               end
               default: ;
            endcase
         end else if (!spi_read_n && spi_mem_addr == 3'd0) begin
            rrdy <= 1'b0;
         end
      end
   end

   // ---------------- monitor ----------------
   int          valid_cnt = 0;
   int          valid_t [$];
   logic        prev_v = 1'b0;
   logic [47:0] e;

   always @(negedge clk) begin
      if (reset_n && sample_valid) begin
         valid_cnt++;
         valid_t.push_back(cyc);
         check("valid_one_cycle", 64'(prev_v), 64'd0);
         if (exp_q.size() == 0) begin
            check("sample_expected", 64'd0, 64'd1);
         end else begin
            e = exp_q.pop_front();
            check("sample_xyz", 64'({sample_x, sample_y, sample_z}), 64'(e));
         end
      end
      prev_v = sample_valid;
   end

   // ---------------- stimulus ----------------
   task automatic rand_regs();
      for (int a = 6'h28; a <= 6'h2D; a++) regs[a] = 8'($urandom);
   endtask

   task automatic wait_valid(input int n, input int bound, input string nm);
      int i = 0;
      while (valid_cnt < n && i < bound) begin
         @(negedge clk);
         i++;
      end
      check(nm, 64'(valid_cnt >= n), 64'd1);
      rand_regs();
   endtask

   task automatic wait_busy_done(input int bound, input string nm);
      int i = 0;
      while (!busy && i < bound) begin
         @(negedge clk);
         i++;
      end
      while (busy && i < bound) begin
         @(negedge clk);
         i++;
      end
      check(nm, 64'(i < bound), 64'd1);
   endtask

   int          n;
   int          i;
   int          sz;
   int          to_t;
   logic [18:0] w;

   initial begin
      for (int a = 0; a < 64; a++) regs[a] = 8'($urandom);
      regs[6'h28] = 8'h01; regs[6'h29] = 8'h80; regs[6'h2A] = 8'hFF;
      regs[6'h2B] = 8'h7F; regs[6'h2C] = 8'h00; regs[6'h2D] = 8'h00;
      regs[6'h0F] = 8'h32;
      enable  = 1'b1;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_select", 64'(spi_select), 64'd0);
      check("rst_read_n", 64'(spi_read_n), 64'd1);
      check("rst_write_n", 64'(spi_write_n), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_valid", 64'(sample_valid), 64'd0);
      check("rst_timeout", 64'(timeout_err), 64'd0);
      check("rst_samples", 64'({sample_x, sample_y, sample_z}), 64'd0);
      reset_n = 1'b1;

      // Power-up: CLR then INIT
      wait_busy_done(3000, "init_done");
      w = wlog[0];
      check("clr_status_write", 64'(w), 64'({3'd2, 16'h0000}));
      w = wlog[1];
      check("init_sso_write", 64'(w), 64'({3'd3, 16'h0400}));
      w = wlog[wlog.size() - 1];
      check("init_release", 64'(w), 64'({3'd3, 16'h0000}));
      check("init_mosi_reg", 64'(mosi[mosi.size() - 2]), 64'h20);
      check("init_mosi_val", 64'(mosi[mosi.size() - 1]), 64'h57);
      check("init_ss_high", 64'(ss), 64'd0);
`ifdef LIS3DH_WHOAMI_CHECK_EN
      check("whoami_mosi", 64'(mosi[0]), 64'h8F);
      check("id_err_bad", 64'(id_err), 64'd1);
`endif

      // First burst with fixed register contents
      wait_valid(1, 6000, "first_sample");
      check("first_x", 64'(sample_x), 64'h8001);
      check("first_y", 64'(sample_y), 64'h7FFF);
      check("first_z", 64'(sample_z), 64'h0000);
      check("ss_low_all_bytes", 64'(ss_err), 64'd0);

      // Periodic spacing with random data
      wait_valid(2, 5000, "sample2");
      wait_valid(3, 5000, "sample3");
      wait_valid(4, 5000, "sample4");
      for (int k = 1; k < 4; k++)
         check("spacing", 64'(valid_t[k] - valid_t[k-1]), 64'(Period));

      // Drop enable mid-burst
      i = 0;
      while (!busy && i < 4100) begin
         @(negedge clk);
         i++;
      end
      check("burst_seen", 64'(busy), 64'd1);
      enable = 1'b0;
      n = valid_cnt;
      wait_valid(n + 1, 1000, "disabled_burst_completes");
      repeat (9000) @(negedge clk);
      check("no_pulse_when_disabled", 64'(valid_cnt), 64'(n + 1));

      // Timeout on byte 3 of the next burst
      enable  = 1'b1;
      kill_at = bursts + 1;
      n = valid_cnt;
      i = 0;
      while (!timeout_err && i < 12000) begin
         @(negedge clk);
         i++;
      end
      to_t = cyc;
      check("timeout_set", 64'(timeout_err), 64'd1);
      check("timeout_latency_ok", 64'((to_t - kill_t >= int'(Timeout)) &&
                                      (to_t - kill_t <= int'(Timeout) + 8)), 64'd1);
      i = 0;
      while (busy && i < 100) begin
         @(negedge clk);
         i++;
      end
      check("timeout_busy_drop", 64'(busy), 64'd0);
      w = wlog[wlog.size() - 1];
      check("timeout_release", 64'(w), 64'({3'd3, 16'h0000}));
      check("timeout_ss_high", 64'(ss), 64'd0);
      check("timeout_no_sample", 64'(valid_cnt), 64'(n));
      wait_valid(n + 1, 9000, "post_timeout_sample");
      check("timeout_sticky", 64'(timeout_err), 64'd1);

      // Reset during the byte-4 read of a burst
      i = 0;
      while (!(spi_select && !spi_read_n && fbytes == 5 && fcmd == 8'hE8) && i < 9000) begin
         @(negedge clk);
         i++;
      end
      check("byte4_read_seen", 64'(spi_select && !spi_read_n), 64'd1);
      regs[6'h0F] = 8'h33;
      sz = wlog.size();
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_select", 64'(spi_select), 64'd0);
      check("midrst_read_n", 64'(spi_read_n), 64'd1);
      check("midrst_write_n", 64'(spi_write_n), 64'd1);
      @(negedge clk);
      reset_n = 1'b1;
      check("midrst_timeout_clr", 64'(timeout_err), 64'd0);
      wait_busy_done(3000, "reinit_done");
      w = wlog[sz];
      check("restart_at_clr", 64'(w), 64'({3'd2, 16'h0000}));
      check("roe_cleared", 64'(roe), 64'd0);
`ifdef LIS3DH_WHOAMI_CHECK_EN
      check("id_err_good", 64'(id_err), 64'd0);
`endif
      n = valid_cnt;
      wait_valid(n + 1, 9000, "post_reset_sample");

      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      check("ss_low_all_bytes_end", 64'(ss_err), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
